// File: rtl/ex_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage_if : ID/EX inputs, EX/MEM outputs and pipeline control of EX    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int REG_ADDR_W = 5
);
    logic [ADDR_W-1:0]     IDPC;
    logic                  IDEn;
    logic [3:0]            IDALUOp;
    logic [DATA_W-1:0]     IDALUIn0;
    logic [DATA_W-1:0]     IDALUIn1;
    logic [1:0]            IDMemOp;
    logic [DATA_W-1:0]     IDMemWrData;
    logic [REG_ADDR_W-1:0] IDDstAddr;
    logic                  IDGPRWE_;
    logic                  Stall;
    logic                  Flush;
    logic                  ExBusy;
    logic [ADDR_W-1:0]     EXPC;
    logic                  EXEn;
    logic [DATA_W-1:0]     EXResult;
    logic [1:0]            EXMemOp;
    logic [DATA_W-1:0]     EXMemWrData;
    logic [REG_ADDR_W-1:0] EXDstAddr;
    logic                  EXGPRWE_;
    logic                  EXOverflow;

    modport master (
        output IDPC, IDEn, IDALUOp, IDALUIn0, IDALUIn1, IDMemOp, IDMemWrData,
               IDDstAddr, IDGPRWE_, Stall, Flush,
        input  ExBusy, EXPC, EXEn, EXResult, EXMemOp, EXMemWrData, EXDstAddr,
               EXGPRWE_, EXOverflow
    );

    modport slave (
        input  IDPC, IDEn, IDALUOp, IDALUIn0, IDALUIn1, IDMemOp, IDMemWrData,
               IDDstAddr, IDGPRWE_, Stall, Flush,
        output ExBusy, EXPC, EXEn, EXResult, EXMemOp, EXMemWrData, EXDstAddr,
               EXGPRWE_, EXOverflow
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage : execute stage, single-cycle ALU plus iterative MULU/DIVU/REMU |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int REG_ADDR_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADDS = 4'h4;
    localparam logic [3:0] OP_ADDU = 4'h5;
    localparam logic [3:0] OP_SUBS = 4'h6;
    localparam logic [3:0] OP_SUBU = 4'h7;
    localparam logic [3:0] OP_SHRL = 4'h8;
    localparam logic [3:0] OP_SHLL = 4'h9;
    localparam logic [3:0] OP_MULU = 4'hA;
    localparam logic [3:0] OP_DIVU = 4'hB;
    localparam logic [3:0] OP_REMU = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [3:0]            it_op_q, it_op_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]     opa_q, opa_d;
    logic [DATA_W-1:0]     opb_q, opb_d;

    logic [ADDR_W-1:0]     ex_pc_q, ex_pc_d;
    logic                  ex_en_q, ex_en_d;
    logic [DATA_W-1:0]     ex_result_q, ex_result_d;
    logic [1:0]            ex_memop_q, ex_memop_d;
    logic [DATA_W-1:0]     ex_wrdata_q, ex_wrdata_d;
    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic                  ex_gprwe_n_q, ex_gprwe_n_d;
    logic                  ex_ovf_q, ex_ovf_d;

    logic                  is_iter;
    logic                  start;
    logic                  ex_busy;
    logic [DATA_W-1:0]     alu_sum;
    logic [DATA_W-1:0]     alu_diff;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_ovf;
    logic [DATA_W-1:0]     mul_acc_next;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_sub;
    logic                  div_ge;
    logic [DATA_W-1:0]     iter_res;

    assign is_iter = (bus.IDALUOp == OP_MULU) || (bus.IDALUOp == OP_DIVU) ||
                     (bus.IDALUOp == OP_REMU);
    assign start   = bus.IDEn && is_iter && !bus.Flush;
    assign ex_busy = ((state_q == S_IDLE) && start) || (state_q == S_BUSY);

    assign alu_sum  = bus.IDALUIn0 + bus.IDALUIn1;
    assign alu_diff = bus.IDALUIn0 - bus.IDALUIn1;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.IDALUOp)
            OP_NOP:  alu_res = '0;
            OP_AND:  alu_res = bus.IDALUIn0 & bus.IDALUIn1;
            OP_OR:   alu_res = bus.IDALUIn0 | bus.IDALUIn1;
            OP_XOR:  alu_res = bus.IDALUIn0 ^ bus.IDALUIn1;
            OP_ADDS: begin
                alu_res = alu_sum;
                alu_ovf = (bus.IDALUIn0[MSB] == bus.IDALUIn1[MSB]) &&
                          (alu_sum[MSB] != bus.IDALUIn0[MSB]);
            end
            OP_ADDU: alu_res = alu_sum;
            OP_SUBS: begin
                alu_res = alu_diff;
                alu_ovf = (bus.IDALUIn0[MSB] != bus.IDALUIn1[MSB]) &&
                          (alu_diff[MSB] != bus.IDALUIn0[MSB]);
            end
            OP_SUBU: alu_res = alu_diff;
            OP_SHRL: alu_res = bus.IDALUIn0 >> bus.IDALUIn1[CNT_W-1:0];
            OP_SHLL: alu_res = bus.IDALUIn0 << bus.IDALUIn1[CNT_W-1:0];
            OP_MULU, OP_DIVU, OP_REMU: alu_res = '0;
            default: alu_res = bus.IDALUIn0;
        endcase
    end

    // Iterative datapath: MULU keeps product in acc, multiplicand in opa, multiplier in opb.
    // DIVU/REMU keep partial remainder in acc and shift dividend-in/quotient-out through opa.
    assign mul_acc_next = acc_q + (opb_q[0] ? opa_q : '0);
    assign div_shift    = {acc_q, opa_q[MSB]};
    assign div_sub      = div_shift - {1'b0, opb_q};
    assign div_ge       = (div_shift >= {1'b0, opb_q});
    assign iter_res     = (it_op_q == OP_DIVU) ? opa_q : acc_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        it_op_d = it_op_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    count_d = '0;
                    it_op_d = bus.IDALUOp;
                    acc_d   = '0;
                    opa_d   = bus.IDALUIn0;
                    opb_d   = bus.IDALUIn1;
                end
            end
            S_BUSY: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (it_op_q == OP_MULU) begin
                        acc_d = mul_acc_next;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end else begin
                        acc_d = div_ge ? div_sub[DATA_W-1:0] : div_shift[DATA_W-1:0];
                        opa_d = {opa_q[DATA_W-2:0], div_ge};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.Stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ex_pc_d      = ex_pc_q;
        ex_en_d      = ex_en_q;
        ex_result_d  = ex_result_q;
        ex_memop_d   = ex_memop_q;
        ex_wrdata_d  = ex_wrdata_q;
        ex_dst_d     = ex_dst_q;
        ex_gprwe_n_d = ex_gprwe_n_q;
        ex_ovf_d     = ex_ovf_q;
        if (bus.Stall) begin
            ex_pc_d = ex_pc_q;
        end else if (bus.Flush || ex_busy) begin
            ex_pc_d      = '0;
            ex_en_d      = 1'b0;
            ex_result_d  = '0;
            ex_memop_d   = '0;
            ex_wrdata_d  = '0;
            ex_dst_d     = '0;
            ex_gprwe_n_d = 1'b1;
            ex_ovf_d     = 1'b0;
        end else begin
            ex_pc_d      = bus.IDPC;
            ex_en_d      = bus.IDEn;
            ex_result_d  = (state_q == S_DONE) ? iter_res : alu_res;
            ex_memop_d   = bus.IDMemOp;
            ex_wrdata_d  = bus.IDMemWrData;
            ex_dst_d     = bus.IDDstAddr;
            // A signed overflow suppresses the register write-back.
            ex_gprwe_n_d = bus.IDGPRWE_ | alu_ovf;
            ex_ovf_d     = alu_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            it_op_q      <= OP_NOP;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            ex_pc_q      <= '0;
            ex_en_q      <= 1'b0;
            ex_result_q  <= '0;
            ex_memop_q   <= '0;
            ex_wrdata_q  <= '0;
            ex_dst_q     <= '0;
            ex_gprwe_n_q <= 1'b1;
            ex_ovf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            it_op_q      <= it_op_d;
            acc_q        <= acc_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            ex_pc_q      <= ex_pc_d;
            ex_en_q      <= ex_en_d;
            ex_result_q  <= ex_result_d;
            ex_memop_q   <= ex_memop_d;
            ex_wrdata_q  <= ex_wrdata_d;
            ex_dst_q     <= ex_dst_d;
            ex_gprwe_n_q <= ex_gprwe_n_d;
            ex_ovf_q     <= ex_ovf_d;
        end
    end

    assign bus.ExBusy      = ex_busy;
    assign bus.EXPC        = ex_pc_q;
    assign bus.EXEn        = ex_en_q;
    assign bus.EXResult    = ex_result_q;
    assign bus.EXMemOp     = ex_memop_q;
    assign bus.EXMemWrData = ex_wrdata_q;
    assign bus.EXDstAddr   = ex_dst_q;
    assign bus.EXGPRWE_    = ex_gprwe_n_q;
    assign bus.EXOverflow  = ex_ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_stage : randomized scoreboard bench for ex_stage                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ex_stage;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 30;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  memop;
        logic [31:0] wd;
        logic [4:0]  dst;
        logic        we_n;
    } instr_t;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] res;
        logic [1:0]  memop;
        logic [31:0] wd;
        logic [4:0]  dst;
        logic        we_n;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    ex_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

    ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: results straight from the arithmetic definition of each op.
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'h0: return 32'h0;
            4'h1: return a & b;
            4'h2: return a | b;
            4'h3: return a ^ b;
            4'h4, 4'h5: return a + b;
            4'h6, 4'h7: return a - b;
            4'h8: return a >> b[4:0];
            4'h9: return a << b[4:0];
            4'hA: begin p = 64'(a) * 64'(b); return p[31:0]; end
            4'hB: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hC: return (b == 0) ? a : a % b;
            default: return a;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        longint s;
        if (op == 4'h4)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'h6) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic exp_t model(input instr_t in);
        exp_t e;
        e.pc    = in.pc;
        e.res   = model_res(in.op, in.a, in.b);
        e.memop = in.memop;
        e.wd    = in.wd;
        e.dst   = in.dst;
        e.ovf   = model_ovf(in.op, in.a, in.b);
        e.we_n  = in.we_n | e.ovf;
        return e;
    endfunction

    function automatic logic [31:0] rword();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        instr_t in;
        in.pc    = 30'($urandom);
        in.en    = 1'b1;
        in.op    = op;
        in.a     = a;
        in.b     = b;
        in.memop = 2'($urandom);
        in.wd    = 32'($urandom);
        in.dst   = 5'($urandom);
        in.we_n  = 1'($urandom);
        return in;
    endfunction

    task automatic drive(input instr_t in);
        bus.IDPC        = in.pc;
        bus.IDEn        = in.en;
        bus.IDALUOp     = in.op;
        bus.IDALUIn0    = in.a;
        bus.IDALUIn1    = in.b;
        bus.IDMemOp     = in.memop;
        bus.IDMemWrData = in.wd;
        bus.IDDstAddr   = in.dst;
        bus.IDGPRWE_    = in.we_n;
    endtask

    task automatic drive_bubble();
        instr_t in;
        in = '0;
        in.we_n = 1'b1;
        drive(in);
    endtask

    task automatic idle_cycles(input int n);
        drive_bubble();
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one ID/EX entry and holds it until the stage consumes it.
    task automatic issue(input instr_t in, input int done_stall, input bit rnd_stall);
        int busy_cnt;
        int held;
        int exp_busy;
        bit was_busy;
        bit done;
        busy_cnt = 0;
        held     = 0;
        was_busy = 1'b0;
        done     = 1'b0;
        exp_busy = (in.en && (in.op inside {4'hA, 4'hB, 4'hC})) ? 33 : 0;
        drive(in);
        bus.Flush = 1'b0;
        bus.Stall = rnd_stall && ($urandom_range(0, 3) == 0);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (bus.ExBusy) begin
                busy_cnt++;
                was_busy = 1'b1;
            end else if (!bus.Stall) begin
                if (in.en) sb.push_back(model(in));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                if (was_busy && !bus.ExBusy && held < done_stall) begin
                    bus.Stall = 1'b1;
                    held++;
                end else begin
                    bus.Stall = rnd_stall && ($urandom_range(0, 3) == 0);
                end
            end
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL consume_timeout op=%h: got no consume in 400 cycles, required consume",
                     in.op);
        end
        checks++;
        if (busy_cnt != exp_busy) begin
            fails++;
            $display("FAIL busy_cycles op=%h: got %0d, required %0d", in.op, busy_cnt, exp_busy);
        end
        bus.Stall = 1'b0;
    endtask

    // Monitor: every non-stalled edge that leaves EXEn=1 must match the scoreboard head.
    initial begin
        bit last_stall;
        exp_t got;
        exp_t e;
        last_stall = 1'b1;
        forever begin
            @(negedge clk);
            if (!last_stall && bus.EXEn === 1'b1) begin
                got = {bus.EXPC, bus.EXResult, bus.EXMemOp, bus.EXMemWrData, bus.EXDstAddr,
                       bus.EXGPRWE_, bus.EXOverflow};
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL exmem_unexpected: got pc=%h res=%h, required no valid output",
                             got.pc, got.res);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL exmem: got pc=%h res=%h mop=%h wd=%h dst=%h we_n=%b ovf=%b, required pc=%h res=%h mop=%h wd=%h dst=%h we_n=%b ovf=%b",
                                 got.pc, got.res, got.memop, got.wd, got.dst, got.we_n, got.ovf,
                                 e.pc, e.res, e.memop, e.wd, e.dst, e.we_n, e.ovf);
                    end
                end
            end
            last_stall = bus.Stall;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_values(input string name);
        logic [ADDR_W+DATA_W*2+REG_ADDR_W+6:0] got;
        logic [ADDR_W+DATA_W*2+REG_ADDR_W+6:0] req;
        got = {bus.ExBusy, bus.EXPC, bus.EXEn, bus.EXResult, bus.EXMemOp, bus.EXMemWrData,
               bus.EXDstAddr, bus.EXGPRWE_, bus.EXOverflow};
        req = '0;
        req[1] = 1'b1;
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        instr_t in;
        bit leaked;
        reset = 1'b1;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        drive_bubble();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(mk(4'h4, 32'h7FFF_FFFF, 32'h1), 0, 1'b0);
        issue(mk(4'h5, 32'h7FFF_FFFF, 32'h1), 0, 1'b0);
        issue(mk(4'h6, 32'h8000_0000, 32'h1), 0, 1'b0);
        issue(mk(4'h7, 32'h8000_0000, 32'h1), 0, 1'b0);
        issue(mk(4'h8, 32'hF000_0000, 32'd36), 0, 1'b0);
        issue(mk(4'h9, 32'h0000_0003, 32'd31), 0, 1'b0);
        issue(mk(4'hA, 32'd1234, 32'd5678), 0, 1'b0);
        issue(mk(4'hB, 32'd100, 32'd7), 0, 1'b0);
        issue(mk(4'hC, 32'd100, 32'd7), 0, 1'b0);
        issue(mk(4'hB, 32'hDEAD_BEEF, 32'd0), 0, 1'b0);
        issue(mk(4'hC, 32'd9, 32'd0), 0, 1'b0);
        issue(mk(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 3, 1'b0);
        issue(mk(4'h1, 32'h1234_5678, 32'h0F0F_0F0F), 0, 1'b0);
        idle_cycles(2);

        // Flush after ten BUSY cycles: the partial product must never reach EX/MEM.
        drive(mk(4'hA, 32'd1234, 32'd5678));
        repeat (11) @(posedge clk);
        #1;
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        drive_bubble();
        @(negedge clk);
        checks++;
        if (bus.ExBusy !== 1'b0 || bus.EXEn !== 1'b0) begin
            fails++;
            $display("FAIL flush_busy: got ExBusy=%b EXEn=%b, required 0 0", bus.ExBusy, bus.EXEn);
        end
        leaked = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.EXEn !== 1'b0 || bus.ExBusy !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            fails++;
            $display("FAIL flush_leak: got late activity, required EXEn=0 ExBusy=0");
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a divide.
        drive(mk(4'hB, 32'd1000, 32'd3));
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_bubble();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset_mid_busy");
        @(posedge clk);
        #1;
        issue(mk(4'hC, 32'd1000, 32'd3), 0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            in = mk(4'($urandom_range(0, 15)), rword(), rword());
            if ($urandom_range(0, 9) == 0) begin
                in = '0;
                in.we_n = 1'b1;
            end
            issue(in, $urandom_range(0, 2), 1'b1);
        end

        idle_cycles(5);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
